// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Iterative 32x32 shift-and-add multiplier returning the low 32 bits of the
// product. Because only the low half is kept, the result is the same for
// signed and unsigned operands. Each RUN cycle retires one multiplier bit
// through a single 32-bit adder (carry-in 0, carry-out dropped).
//
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN
//   defined   -> RUN also ends once the remaining multiplier bits are all zero
//   undefined -> fixed 32-cycle RUN phase
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  request a multiply (accepted in IDLE or DONE only)
//   a        in  32  multiplicand, sampled on the accepting edge
//   b        in  32  multiplier, sampled on the accepting edge
//   busy     out  1  high while an operation is in RUN
//   done     out  1  one-cycle pulse, first cycle product is valid
//   product  out 32  result, held until the next completion or reset
//
// Handshake: start is a request sampled on the rising edge while the block
// is in IDLE or DONE; busy rises on the accepting edge; done pulses for one
// cycle when product updates; start seen during RUN is ignored.
// -----------------------------------------------------------------------------
module seq_multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] acc;
   logic [4:0]  count;

   logic [31:0] adder_sum;
   logic [31:0] acc_step;
   logic [31:0] mplier_shift;
   logic        last_cycle;

   // Single adder instance; carry-out is simply discarded by the 32-bit width.
   assign adder_sum    = acc + mcand;
   assign acc_step     = mplier[0] ? adder_sum : acc;
   assign mplier_shift = mplier >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
   // Once the unprocessed multiplier bits are all zero, acc can no longer
   // change, so the result is final.
   assign last_cycle = (count == 5'd31) || (mplier_shift == 32'd0);
`else
   assign last_cycle = (count == 5'd31);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mcand   <= 32'd0;
         mplier  <= 32'd0;
         acc     <= 32'd0;
         count   <= 5'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= 32'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= 32'd0;
                  count  <= 5'd0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier_shift;
               count  <= count + 5'd1;
               if (last_cycle) begin
                  // Publish the post-update accumulator on the same edge.
                  product <= acc_step;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//
// Directed bench for seq_multiplier. Vectors carry hand-computed products and
// the expected done latency for both builds (fixed 32 or early-terminating).
// Hand-written sequences cover reset, ignored start while busy and start held
// through DONE.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int checks   = 0;
   int failures = 0;

   seq_multiplier dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_product;
      int          n_fixed;
      int          n_early;
   } vec_t;

   vec_t vecs[9];

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int exp_latency(input int n_fixed, input int n_early);
`ifdef SEQ_MULT_EARLY_TERM_EN
      exp_latency = n_early;
`else
      exp_latency = n_fixed;
`endif
   endfunction

   // Waits (bounded) for done after the accepting edge; n is the edge index.
   // Checks busy/done exclusivity and busy staying high until completion.
   task automatic wait_done(input string name, output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         check({name, " busy&done"}, {31'd0, busy & done}, 32'd0);
         if (done) begin
            n = i;
            break;
         end
         check({name, " busy in run"}, {31'd0, busy}, 32'd1);
      end
      if (n == 0) check({name, " timeout"}, 32'd0, 32'd1);
   endtask

   // Issues one operation from IDLE, scrambles operands after acceptance.
   task automatic run_vec(input string name, input vec_t v);
      int n;
      a     = v.a;
      b     = v.b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      check({name, " busy at edge0"}, {31'd0, busy}, 32'd1);
      check({name, " done at edge0"}, {31'd0, done}, 32'd0);
      wait_done(name, n);
      check({name, " latency"}, n, exp_latency(v.n_fixed, v.n_early));
      check({name, " product"}, product, v.exp_product);
      @(posedge clk);
      #1;
      check({name, " done one cycle"}, {31'd0, done}, 32'd0);
      check({name, " product held"}, product, v.exp_product);
   endtask

   // ---------------- test body ----------------
   initial begin
      int n;
      int pulse_edge;

      vecs[0] = '{32'd3,        32'd5,        32'd15,        32, 3};
      vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  32, 32};
      vecs[2] = '{32'h12345678, 32'h0,        32'h0,         32, 1};
      vecs[3] = '{32'h00010000, 32'h00010000, 32'h0,         32, 17};
      vecs[4] = '{32'hDEADBEEF, 32'h1,        32'hDEADBEEF,  32, 1};
      vecs[5] = '{32'd7,        32'd6,        32'd42,        32, 3};
      vecs[6] = '{32'h00000003, 32'h80000000, 32'h80000000,  32, 32};
      vecs[7] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,  32, 2};
      vecs[8] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001,  32, 16};

      rst_n = 1'b0;
      start = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      #2;
      check("reset busy",    {31'd0, busy}, 32'd0);
      check("reset done",    {31'd0, done}, 32'd0);
      check("reset product", product,       32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // start pulsed while busy is ignored; then start held through DONE.
      pulse_edge = exp_latency(10, 2);
      a     = 32'd7;
      b     = 32'd6;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (pulse_edge - 1) @(posedge clk);
      #1;
      a     = 32'd9;
      b     = 32'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ignored busy", {31'd0, busy}, 32'd1);
      wait_done("ignored", n);
      check("ignored latency", n + pulse_edge, exp_latency(32, 3));
      check("ignored product", product, 32'd42);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b done pulse", {31'd0, done}, 32'd0);
      check("b2b busy",       {31'd0, busy}, 32'd1);
      check("b2b product held", product, 32'd42);
      wait_done("b2b", n);
      check("b2b latency", n, exp_latency(32, 4));
      check("b2b product", product, 32'd81);
      @(posedge clk);
      #1;

      // Reset asserted at edge 15 of an operation.
      a     = 32'd2;
      b     = 32'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst busy",    {31'd0, busy}, 32'd0);
      check("midrst done",    {31'd0, done}, 32'd0);
      check("midrst product", product,       32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) n++;
      end
      check("post reset quiet", n, 32'd0);
      check("post reset product", product, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
